pause_dim_ctrl: RTL and testbench

//  Pause arbitration and screen-dim stage between HVGEN's RGB/sync outputs and arcade_video.
//  - Merges user pause toggle, OSD-open pause and hiscore-access pause into the single core pause.
//  - After DIM_DELAY paused clocks, fades the picture frame by frame down to 50% brightness.
//  - Re-registers video and syncs on ce_pix so timing stays aligned.

---
 rtl/pause_dim_ctrl.sv | 120 ++++++++++++
 tb/tb_pause_dim_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/pause_dim_ctrl.sv
// pause_dim_ctrl: merges pause sources, fades the picture after a long pause, re-registers video on ce_pix.
module pause_dim_ctrl #(
    parameter logic [31:0] DIM_DELAY   = 32'h1C9C3800,
    parameter int          FADE_FRAMES = 4,
    parameter int          MAX_LEVEL   = 4
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        btn_pause,
    input  logic        osd_open,
    input  logic        osd_pause_en,
    input  logic        hs_access,
    input  logic        ce_pix,
    input  logic [11:0] rgb_in,
    input  logic        hblank_in,
    input  logic        vblank_in,
    input  logic        hs_in,
    input  logic        vs_in,
    output logic        pause,
    output logic        user_paused,
    output logic [2:0]  dim_level,
    output logic [11:0] rgb_out,
    output logic        hblank_out,
    output logic        vblank_out,
    output logic        hs_out,
    output logic        vs_out
);
    localparam int FW = FADE_FRAMES > 1 ? $clog2(FADE_FRAMES) : 1;

    typedef enum logic [1:0] {RUN, WAIT, FADE, DIM} state_t;

    state_t          state_q, state_d;
    logic            btn_q, user_paused_q, user_paused_d;
    logic [31:0]     timer_q, timer_d;
    logic [FW-1:0]   frame_cnt_q, frame_cnt_d;
    logic [2:0]      dim_level_q, dim_level_d;
    logic [11:0]     rgb_q, rgb_d;
    logic            hblank_q, vblank_q, hs_q, vs_q;
    logic            vb_rise;

    function automatic logic [3:0] dim4(input logic [3:0] c, input logic [2:0] l);
        logic [6:0] p;
        p = 7'(c) * 7'(l);
        return c - p[6:3];
    endfunction

    always_comb begin
        pause         = user_paused_q | hs_access | (osd_open & osd_pause_en);
        // vblank_q is vblank_in one ce_pix ago, so it doubles as the edge detector
        vb_rise       = ce_pix & vblank_in & ~vblank_q;
        user_paused_d = user_paused_q ^ (btn_pause & ~btn_q);
        timer_d       = !pause ? '0 : (timer_q == DIM_DELAY ? timer_q : timer_q + 32'd1);
        rgb_d         = (hblank_in | vblank_in) ? '0 :
                        {dim4(rgb_in[11:8], dim_level_q), dim4(rgb_in[7:4], dim_level_q), dim4(rgb_in[3:0], dim_level_q)};
        state_d       = state_q;
        frame_cnt_d   = frame_cnt_q;
        dim_level_d   = dim_level_q;
        if (!pause) begin
            state_d     = RUN;
            frame_cnt_d = '0;
            dim_level_d = '0;
        end else begin
            case (state_q)
                RUN:  state_d = WAIT;
                WAIT: if (timer_q == DIM_DELAY) begin
                    state_d     = FADE;
                    frame_cnt_d = '0;
                end
                FADE: if (vb_rise) begin
                    if (frame_cnt_q == FW'(FADE_FRAMES - 1)) begin
                        frame_cnt_d = '0;
                        dim_level_d = dim_level_q + 3'd1;
                        state_d     = (dim_level_q + 3'd1 == 3'(MAX_LEVEL)) ? DIM : FADE;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= RUN;
            btn_q         <= 1'b0;
            user_paused_q <= 1'b0;
            timer_q       <= '0;
            frame_cnt_q   <= '0;
            dim_level_q   <= '0;
            rgb_q         <= '0;
            hblank_q      <= 1'b1;
            vblank_q      <= 1'b1;
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            btn_q         <= btn_pause;
            user_paused_q <= user_paused_d;
            timer_q       <= timer_d;
            frame_cnt_q   <= frame_cnt_d;
            dim_level_q   <= dim_level_d;
            if (ce_pix) begin
                rgb_q    <= rgb_d;
                hblank_q <= hblank_in;
                vblank_q <= vblank_in;
                hs_q     <= hs_in;
                vs_q     <= vs_in;
            end
        end
    end

    assign user_paused = user_paused_q;
    assign dim_level   = dim_level_q;
    assign rgb_out     = rgb_q;
    assign hblank_out  = hblank_q;
    assign vblank_out  = vblank_q;
    assign hs_out      = hs_q;
    assign vs_out      = vs_q;
endmodule

// File: tb/tb_pause_dim_ctrl.sv
// tb_pause_dim_ctrl: directed stimulus with a queued scoreboard drained by a negedge monitor.
module tb_pause_dim_ctrl;
  logic        clk = 1'b0, reset_n;
  logic        btn_pause, osd_open, osd_pause_en, hs_access, ce_pix;
  logic [11:0] rgb_in;
  logic        hblank_in, vblank_in, hs_in, vs_in;
  logic        pause, user_paused;
  logic [2:0]  dim_level;
  logic [11:0] rgb_out;
  logic        hblank_out, vblank_out, hs_out, vs_out;
  typedef struct {int sel; logic [11:0] exp; string name;} exp_t;
  exp_t        q[$];
  exp_t        e;
  logic [11:0] act;
  int          total = 0, bad = 0;
  pause_dim_ctrl #(.DIM_DELAY(32'd100), .FADE_FRAMES(2), .MAX_LEVEL(4)) dut (
    .clk_sys(clk), .reset_n(reset_n), .btn_pause(btn_pause), .osd_open(osd_open),
    .osd_pause_en(osd_pause_en), .hs_access(hs_access), .ce_pix(ce_pix), .rgb_in(rgb_in),
    .hblank_in(hblank_in), .vblank_in(vblank_in), .hs_in(hs_in), .vs_in(vs_in),
    .pause(pause), .user_paused(user_paused), .dim_level(dim_level), .rgb_out(rgb_out),
    .hblank_out(hblank_out), .vblank_out(vblank_out), .hs_out(hs_out), .vs_out(vs_out)
  );
  always #5 clk = ~clk;
  function automatic logic [11:0] observe(input int sel);
    case (sel)
      0:       return {11'd0, pause};
      1:       return {11'd0, user_paused};
      2:       return {9'd0, dim_level};
      3:       return rgb_out;
      4:       return {11'd0, hblank_out};
      5:       return {11'd0, vblank_out};
      6:       return {11'd0, hs_out};
      default: return {11'd0, vs_out};
    endcase
  endfunction
  always @(negedge clk) begin
    while (q.size() > 0) begin
      e   = q.pop_front();
      act = observe(e.sel);
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("FAIL %s: got %h want %h", e.name, act, e.exp);
      end
    end
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input int sel, input logic [11:0] v, input string n);
    q.push_back('{sel, v, n});
  endtask
  task automatic chk_now(input int sel, input logic [11:0] v, input string n);
    total++;
    if (observe(sel) !== v) begin
      bad++;
      $display("FAIL %s: got %h want %h (immediate)", n, observe(sel), v);
    end
  endtask
  task automatic vb_edge;
    vblank_in = 1'b1;
    step;
    vblank_in = 1'b0;
    step;
  endtask
  initial begin
    reset_n = 1'b0; btn_pause = 0; osd_open = 0; osd_pause_en = 0; hs_access = 0; ce_pix = 0;
    rgb_in = '0; hblank_in = 0; vblank_in = 0; hs_in = 0; vs_in = 0;
    step; step;
    chk_now(2, 0, "rst_dim_now"); chk_now(1, 0, "rst_user_now");
    chk(0, 0, "rst_pause"); chk(1, 0, "rst_user"); chk(2, 0, "rst_dim"); chk(3, 0, "rst_rgb");
    chk(4, 1, "rst_hblank"); chk(5, 1, "rst_vblank"); chk(6, 0, "rst_hs"); chk(7, 0, "rst_vs");
    step;
    reset_n = 1'b1; ce_pix = 1'b1;
    step; step;
    btn_pause = 1; step;
    chk(1, 1, "toggle_on"); chk(0, 1, "pause_user");
    repeat (49) step;
    chk(1, 1, "hold_no_toggle");
    btn_pause = 0; step; btn_pause = 1; step;
    chk(1, 0, "toggle_off"); chk(0, 0, "pause_off");
    btn_pause = 0; step;
    osd_open = 1; chk(0, 0, "osd_no_en"); step;
    osd_pause_en = 1; chk(0, 1, "osd_en"); step;
    osd_open = 0; osd_pause_en = 0; chk(0, 0, "osd_closed"); step;
    hs_access = 1; repeat (99) step;
    hs_access = 0; step;
    repeat (4) vb_edge;
    chk(2, 0, "short_pause");
    rgb_in = 12'hFFF; hs_access = 1;
    repeat (110) step;
    chk_now(0, 1, "wait_expired_pause"); chk_now(2, 0, "wait_expired_dim");
    vb_edge; chk(2, 0, "one_edge");
    vb_edge; chk(2, 1, "lvl1"); chk(3, 12'hEEE, "rgb_lvl1");
    repeat (4) vb_edge;
    chk(2, 3, "lvl3"); chk(3, 12'hAAA, "rgb_lvl3");
    hs_access = 0; chk(0, 0, "release_a"); step;
    chk(2, 0, "dim_clear"); chk(3, 12'hAAA, "rgb_old_lvl"); step;
    chk(3, 12'hFFF, "rgb_undim");
    hs_access = 1;
    repeat (110) step;
    chk_now(2, 0, "wait_expired_dim_b");
    repeat (8) vb_edge; chk(2, 4, "lvl4");
    repeat (2) vb_edge; chk(2, 4, "lvl_hold");
    btn_pause = 1; step;
    hs_access = 0; chk(1, 1, "swap_user"); chk(0, 1, "swap_pause"); chk(2, 4, "swap_dim");
    btn_pause = 0; step;
    vb_edge; chk(2, 4, "swap_hold");
    rgb_in = 12'hFFF; step; chk(3, 12'h888, "rgb_fff");
    rgb_in = 12'h3A7; step; chk(3, 12'h254, "rgb_3a7");
    ce_pix = 0; rgb_in = 12'hFFF; step; chk(3, 12'h254, "ce_hold");
    ce_pix = 1; hblank_in = 1; step; chk(3, 0, "hblank_black"); chk(4, 1, "hblank_out");
    hblank_in = 0; vblank_in = 1; step; chk(3, 0, "vblank_black"); chk(5, 1, "vblank_out");
    vblank_in = 0; hs_in = 1; vs_in = 1; step;
    chk(6, 1, "hs_out"); chk(7, 1, "vs_out"); chk(3, 12'h888, "rgb_after_blank"); chk(4, 0, "hblank_low");
    btn_pause = 1; step; chk(1, 0, "user_off"); chk(0, 0, "release_b");
    btn_pause = 0; step; chk(2, 0, "dim_clear_b");
    osd_open = 1; osd_pause_en = 1;
    repeat (110) step;
    repeat (2) vb_edge; chk(2, 1, "c_lvl1"); chk(3, 12'hEEE, "c_rgb");
    step;
    #2 reset_n = 0;
    #1;
    chk(0, 1, "rst_mid_pause"); chk(1, 0, "rst_mid_user"); chk(2, 0, "rst_mid_dim");
    chk(3, 0, "rst_mid_rgb"); chk(4, 1, "rst_mid_hblank"); chk(5, 1, "rst_mid_vblank");
    chk(6, 0, "rst_mid_hs"); chk(7, 0, "rst_mid_vs");
    step;
    osd_open = 0; osd_pause_en = 0; reset_n = 1;
    step;
    chk(1, 0, "post_rst_user"); chk(0, 0, "post_rst_pause"); chk(2, 0, "post_rst_dim");
    step; step;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
